// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared encodings for the MEM-stage access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      MT_WORD  = 2'b00,
      MT_HALF  = 2'b01,
      MT_BYTE  = 2'b10,
      MT_BYTEU = 2'b11
   } mem_type_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } mem_state_e;

   localparam logic [3:0] C_BE_WORD    = 4'b1111;
   localparam logic [3:0] C_BE_HALF_LO = 4'b0011;
   localparam logic [3:0] C_BE_HALF_HI = 4'b1100;
   localparam logic [3:0] C_BE_BYTE0   = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Lane steering for sub-word stores/loads and alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
   import mem_ctrl_pkg::*;
(
   input  logic [1:0]  i_addr_lo,
   input  mem_type_e   i_type,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_byte_en,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_misalign
);

   logic [15:0] w_half;
   logic [7:0]  w_byte;

   always_comb begin
      w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
      case (i_addr_lo)
         2'd0:    w_byte = i_rword[7:0];
         2'd1:    w_byte = i_rword[15:8];
         2'd2:    w_byte = i_rword[23:16];
         default: w_byte = i_rword[31:24];
      endcase
   end

   always_comb begin
      o_byte_en  = C_BE_WORD;
      o_wdata    = i_wdata;
      o_rdata    = i_rword;
      o_misalign = 1'b0;
      case (i_type)
         MT_WORD: begin
            o_misalign = |i_addr_lo;
         end
         MT_HALF: begin
            o_byte_en  = i_addr_lo[1] ? C_BE_HALF_HI : C_BE_HALF_LO;
            o_wdata    = {2{i_wdata[15:0]}};
            o_rdata    = {{16{w_half[15]}}, w_half};
            o_misalign = i_addr_lo[0];
         end
         MT_BYTE: begin
            o_byte_en  = C_BE_BYTE0 << i_addr_lo;
            o_wdata    = {4{i_wdata[7:0]}};
            o_rdata    = {{24{w_byte[7]}}, w_byte};
         end
         default: begin
            o_byte_en  = C_BE_BYTE0 << i_addr_lo;
            o_wdata    = {4{i_wdata[7:0]}};
            o_rdata    = {24'd0, w_byte};
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_controller
// Description : MEM-stage sequencer driving a req/ack data-memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_controller
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [1:0]  MemTypeM,
   input  logic [31:0] ALUresultM,
   input  logic [31:0] ReadData2M,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [3:0]  MemByteEn,
   output logic [31:0] MemWData,
   input  logic        MemAck,
   input  logic [31:0] MemRData,
   output logic        StallM,
   output logic [31:0] ReadDataM,
   output logic        MisalignM,
   output logic        MemFaultM
);

   localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   mem_state_e  r_state;
   mem_state_e  w_next;
   logic        r_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_fault;
   logic [15:0] r_cnt;
   logic [1:0]  r_lane;
   mem_type_e   r_type;

   logic        w_idle;
   logic        w_cmd;
   logic        w_go;
   logic        w_tmo;
   logic        w_stall;
   logic [1:0]  w_lane;
   mem_type_e   w_type;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_load;
   logic        w_mis;

   // While busy, the lane/type captured at issue steer the returning word.
   assign w_idle = (r_state == ST_IDLE);
   assign w_lane = w_idle ? ALUresultM[1:0] : r_lane;
   assign w_type = w_idle ? mem_type_e'(MemTypeM) : r_type;

   mem_lane_align u_align (
      .i_addr_lo  (w_lane),
      .i_type     (w_type),
      .i_wdata    (ReadData2M),
      .i_rword    (MemRData),
      .o_byte_en  (w_be),
      .o_wdata    (w_wdata),
      .o_rdata    (w_load),
      .o_misalign (w_mis)
   );

   assign w_cmd = MemReadM | MemWriteM;
   assign w_go  = w_cmd & ~w_mis;
   assign w_tmo = (r_cnt == C_TMO_LAST);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_go) begin
               w_next  = ST_BUSY;
               w_stall = 1'b1;
            end
         end
         ST_BUSY: begin
            w_stall = 1'b1;
            if (MemAck || w_tmo) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_be    <= 4'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_fault <= 1'b0;
         r_cnt   <= 16'd0;
         r_lane  <= 2'd0;
         r_type  <= MT_WORD;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_fault <= 1'b0;
               if (w_go) begin
                  r_req   <= 1'b1;
                  r_we    <= MemWriteM;
                  r_addr  <= {ALUresultM[31:2], 2'b00};
                  r_be    <= w_be;
                  r_wdata <= w_wdata;
                  r_rdata <= 32'd0;
                  r_cnt   <= 16'd0;
                  r_lane  <= ALUresultM[1:0];
                  r_type  <= mem_type_e'(MemTypeM);
               end
            end
            ST_BUSY: begin
               // An ack on the final allowed cycle still counts as success.
               if (MemAck) begin
                  r_req   <= 1'b0;
                  r_we    <= 1'b0;
                  r_rdata <= r_we ? 32'd0 : w_load;
               end else if (w_tmo) begin
                  r_req   <= 1'b0;
                  r_we    <= 1'b0;
                  r_fault <= 1'b1;
                  r_rdata <= 32'd0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
               r_fault <= 1'b0;
            end
         endcase
      end
   end

   assign MemReq    = r_req;
   assign MemWe     = r_we;
   assign MemAddr   = r_addr;
   assign MemByteEn = r_be;
   assign MemWData  = r_wdata;
   assign ReadDataM = r_rdata;
   assign MemFaultM = r_fault;
   assign StallM    = Rst_n & w_stall;
   assign MisalignM = w_idle & w_cmd & w_mis;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_controller
// Description : Directed vector bench for the MEM-stage access controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_controller;

   logic        Clk;
   logic        Rst_n;
   logic        MemReadM;
   logic        MemWriteM;
   logic [1:0]  MemTypeM;
   logic [31:0] ALUresultM;
   logic [31:0] ReadData2M;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [3:0]  MemByteEn;
   logic [31:0] MemWData;
   logic        MemAck;
   logic [31:0] MemRData;
   logic        StallM;
   logic [31:0] ReadDataM;
   logic        MisalignM;
   logic        MemFaultM;

   int total = 0;
   int bad   = 0;

   mem_access_controller #(.TIMEOUT_CYCLES(4)) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .MemTypeM   (MemTypeM),
      .ALUresultM (ALUresultM),
      .ReadData2M (ReadData2M),
      .MemReq     (MemReq),
      .MemWe      (MemWe),
      .MemAddr    (MemAddr),
      .MemByteEn  (MemByteEn),
      .MemWData   (MemWData),
      .MemAck     (MemAck),
      .MemRData   (MemRData),
      .StallM     (StallM),
      .ReadDataM  (ReadDataM),
      .MisalignM  (MisalignM),
      .MemFaultM  (MemFaultM)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  mtype;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      int          waits;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        we;
      logic        mis;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drives one command starting in the current IDLE cycle; returns in the next IDLE cycle.
   task automatic run_vec(input vec_t v, input string nm);
      int  st;
      int  nb;
      bit  acked;
      bit  fin;
      MemReadM   = v.rd;
      MemWriteM  = v.wr;
      MemTypeM   = v.mtype;
      ALUresultM = v.addr;
      ReadData2M = v.sdata;
      MemAck     = 1'b0;
      #1;
      if (v.mis) begin
         chk({nm, "_misalign"}, 32'(MisalignM), 32'd1);
         chk({nm, "_mis_stall"}, 32'(StallM), 32'd0);
         @(negedge Clk); #1;
         chk({nm, "_mis_noreq"}, 32'(MemReq), 32'd0);
         MemReadM  = 1'b0;
         MemWriteM = 1'b0;
         @(negedge Clk); #1;
         return;
      end
      st = 0; nb = 0; acked = 0; fin = 0;
      for (int c = 0; c < 40 && !fin; c++) begin
         MemAck = 1'b0;
         if (StallM) st++;
         if (MemReq) begin
            nb++;
            chk({nm, "_addr"}, MemAddr, {v.addr[31:2], 2'b00});
            chk({nm, "_be"}, 32'(MemByteEn), 32'(v.be));
            chk({nm, "_wdata"}, MemWData, v.wdata);
            chk({nm, "_we"}, 32'(MemWe), 32'(v.we));
            if (nb == v.waits + 1) begin
               MemAck   = 1'b1;
               MemRData = v.rdata;
               acked    = 1;
            end
         end else if (acked) begin
            chk({nm, "_rdata"}, ReadDataM, v.exp_rd);
            chk({nm, "_fault"}, 32'(MemFaultM), 32'd0);
            fin = 1;
         end
         if (!fin) begin
            @(negedge Clk); #1;
         end
      end
      chk({nm, "_completed"}, 32'(fin), 32'd1);
      chk({nm, "_stall_cycles"}, 32'(st), 32'(v.waits + 2));
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
      MemRData  = 32'h5A5A_A5A5;
      @(negedge Clk); #1;
      chk({nm, "_idle_req"}, 32'(MemReq), 32'd0);
      chk({nm, "_idle_stall"}, 32'(StallM), 32'd0);
   endtask

   initial begin
      int  nreq;
      bit  fin;
      vec_t rv;

      vecs[0]  = '{1'b1, 1'b0, 2'b00, 32'h104, 32'h11223344, 32'hDEADBEEF, 0, 4'hF, 32'h11223344, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 2'b10, 32'h203, 32'h11223344, 32'h80FF1234, 0, 4'h8, 32'h44444444, 32'hFFFFFF80, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 2'b11, 32'h203, 32'h11223344, 32'h80FF1234, 0, 4'h8, 32'h44444444, 32'h00000080, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 2'b01, 32'h012, 32'h0000ABCD, 32'hFFFFFFFF, 3, 4'hC, 32'hABCDABCD, 32'h00000000, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 2'b00, 32'h006, 32'h00000000, 32'h00000000, 0, 4'h0, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 2'b01, 32'h202, 32'h11223344, 32'h80017FFF, 1, 4'hC, 32'h33443344, 32'hFFFF8001, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 2'b01, 32'h200, 32'h11223344, 32'h80017FFF, 0, 4'h3, 32'h33443344, 32'h00007FFF, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 2'b10, 32'h201, 32'h11223344, 32'h80FF1234, 2, 4'h2, 32'h44444444, 32'h00000012, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 2'b11, 32'h202, 32'h11223344, 32'h80FF1234, 0, 4'h4, 32'h44444444, 32'h000000FF, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 2'b00, 32'h300, 32'hCAFEF00D, 32'h12345678, 2, 4'hF, 32'hCAFEF00D, 32'h00000000, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 2'b10, 32'h301, 32'h000000A5, 32'h12345678, 1, 4'h2, 32'hA5A5A5A5, 32'h00000000, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 2'b00, 32'h400, 32'h01020304, 32'hDEADBEEF, 0, 4'hF, 32'h01020304, 32'h00000000, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 2'b01, 32'h203, 32'h00000000, 32'h00000000, 0, 4'h0, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 2'b01, 32'h011, 32'h00000000, 32'h00000000, 0, 4'h0, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
      vecs[14] = '{1'b1, 1'b0, 2'b10, 32'h003, 32'h11223344, 32'hA1B2C3D4, 0, 4'h8, 32'h44444444, 32'hFFFFFFA1, 1'b0, 1'b0};

      Rst_n      = 1'b0;
      MemReadM   = 1'b0;
      MemWriteM  = 1'b0;
      MemTypeM   = 2'b00;
      ALUresultM = 32'd0;
      ReadData2M = 32'd0;
      MemAck     = 1'b0;
      MemRData   = 32'd0;
      repeat (2) @(negedge Clk);
      #1;
      chk("rst_req", 32'(MemReq), 32'd0);
      chk("rst_we", 32'(MemWe), 32'd0);
      chk("rst_addr", MemAddr, 32'd0);
      chk("rst_be", 32'(MemByteEn), 32'd0);
      chk("rst_wdata", MemWData, 32'd0);
      chk("rst_rdata", ReadDataM, 32'd0);
      chk("rst_fault", 32'(MemFaultM), 32'd0);
      chk("rst_stall", 32'(StallM), 32'd0);
      chk("rst_misalign", 32'(MisalignM), 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      #1;

      for (int i = 0; i < 15; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Ack while idle must not start anything.
      MemAck = 1'b1;
      @(negedge Clk); #1;
      MemAck = 1'b0;
      chk("idle_ack_req", 32'(MemReq), 32'd0);
      chk("idle_ack_stall", 32'(StallM), 32'd0);
      @(negedge Clk); #1;
      chk("idle_ack_fault", 32'(MemFaultM), 32'd0);

      // Timeout with no ack at all.
      MemReadM   = 1'b1;
      MemTypeM   = 2'b00;
      ALUresultM = 32'h500;
      #1;
      chk("tmo_stall_idle", 32'(StallM), 32'd1);
      nreq = 0;
      fin  = 0;
      for (int c = 0; c < 20 && !fin; c++) begin
         @(negedge Clk); #1;
         if (MemReq) begin
            nreq++;
         end else begin
            fin = 1;
            chk("tmo_fault", 32'(MemFaultM), 32'd1);
            chk("tmo_rdata", ReadDataM, 32'd0);
            chk("tmo_stall_done", 32'(StallM), 32'd0);
         end
      end
      chk("tmo_completed", 32'(fin), 32'd1);
      chk("tmo_req_cycles", 32'(nreq), 32'd4);
      MemReadM = 1'b0;
      @(negedge Clk); #1;
      chk("tmo_fault_clear", 32'(MemFaultM), 32'd0);
      chk("tmo_idle_req", 32'(MemReq), 32'd0);

      // Asynchronous reset in the second busy cycle.
      MemReadM   = 1'b1;
      MemTypeM   = 2'b00;
      ALUresultM = 32'h600;
      @(negedge Clk); #1;
      chk("rstmid_busy1_req", 32'(MemReq), 32'd1);
      @(negedge Clk); #1;
      chk("rstmid_busy2_req", 32'(MemReq), 32'd1);
      Rst_n = 1'b0;
      #1;
      chk("rstmid_req", 32'(MemReq), 32'd0);
      chk("rstmid_stall", 32'(StallM), 32'd0);
      @(negedge Clk);
      MemReadM = 1'b0;
      Rst_n    = 1'b1;
      #1;
      rv = '{1'b1, 1'b0, 2'b00, 32'h604, 32'h0, 32'h12345678, 1, 4'hF, 32'h0, 32'h12345678, 1'b0, 1'b0};
      run_vec(rv, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
